ntwrk_merge_ctrl: RTL and testbench

//  Sequencer for the point->network lookup. Accepts point pairs (shortest-first), reads both points' network IDs,

---
 rtl/ntwrk_merge_ctrl.sv | 136 +++++++++++++
 tb/tb_ntwrk_merge_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ntwrk_merge_ctrl.sv
// ntwrk_merge_ctrl: builds point networks from a pair stream, keeps per-network sizes, reports the largest NUM_NTWRKS
module ntwrk_merge_ctrl #(
  parameter int NUM_POINTS = 1000,
  parameter int NUM_NTWRKS = 3,
  parameter int NUM_CONN   = 1000,
  localparam int PW  = $clog2(NUM_POINTS),
  localparam int IDW = $clog2(NUM_POINTS/2+1),
  localparam int SW  = $clog2(NUM_POINTS+1),
  localparam int CW  = $clog2(NUM_CONN+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PW-1:0]            pointa_in,
  input  logic [PW-1:0]            pointb_in,
  input  logic                     points_vld,
  output logic                     points_rdy,
  input  logic                     flush,
  output logic                     busy,
  output logic [NUM_NTWRKS*SW-1:0] ntwrk_sz,
  output logic                     ntwrk_sz_vld
);
  typedef enum logic [2:0] {IDLE, LOOKUP, DECIDE, MERGE, REPORT, DONE} state_t;
  state_t r_state, w_nxt;
  logic [IDW-1:0] r_pt_id [NUM_POINTS];
  logic [SW-1:0] r_sz [NUM_POINTS/2+1];
  logic [SW-1:0] r_top [NUM_NTWRKS];
  logic [SW-1:0] w_ins [NUM_NTWRKS];
  logic [IDW-1:0] r_next_id, r_rda, r_rdb, r_ida, r_idb, w_jid;
  logic [PW-1:0] r_a, r_b, r_addr;
  logic [CW-1:0] r_conn_cnt;
  logic r_flush_pend;
  logic [NUM_NTWRKS*SW-1:0] r_out;
  logic w_acc, w_skip, w_alloc, w_join, w_merge, w_fin, w_last_m, w_last_r;
  logic [SW-1:0] w_v;
  assign w_acc    = points_vld && r_state == IDLE;
  assign w_skip   = (r_a == r_b) || (r_ida == r_idb && r_ida != '0);
  assign w_alloc  = !w_skip && r_ida == '0 && r_idb == '0;
  assign w_join   = !w_skip && ((r_ida == '0) != (r_idb == '0));
  assign w_merge  = !w_skip && !w_alloc && !w_join;
  assign w_jid    = (r_ida == '0) ? r_idb : r_ida;
  assign w_fin    = (r_conn_cnt == CW'(NUM_CONN)) || r_flush_pend;
  assign w_last_m = r_addr == PW'(NUM_POINTS-1);
  assign w_last_r = r_addr == PW'(NUM_POINTS/2);
  assign w_v      = r_sz[r_addr[IDW-1:0]];
  assign ntwrk_sz = r_out;
  // sorted insert: a strictly larger value displaces an entry, ties keep the earlier one above
  for (genvar k = 0; k < NUM_NTWRKS; k++) begin : g_ins
    if (k == 0) begin : g_h
      assign w_ins[k] = (w_v > r_top[k]) ? w_v : r_top[k];
    end else begin : g_t
      assign w_ins[k] = (w_v > r_top[k-1]) ? r_top[k-1] : (w_v > r_top[k]) ? w_v : r_top[k];
    end
  end
  always_comb begin
    w_nxt = r_state;
    points_rdy = rst_n && r_state == IDLE;
    busy = r_state != IDLE && r_state != DONE;
    ntwrk_sz_vld = r_state == DONE;
    case (r_state)
      IDLE:    w_nxt = w_acc ? LOOKUP : flush ? REPORT : IDLE;
      LOOKUP:  w_nxt = DECIDE;
      DECIDE:  w_nxt = w_merge ? MERGE : w_fin ? REPORT : IDLE;
      MERGE:   w_nxt = !w_last_m ? MERGE : w_fin ? REPORT : IDLE;
      REPORT:  w_nxt = w_last_r ? DONE : REPORT;
      default: w_nxt = DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_POINTS; k++) r_pt_id[k] <= '0;
      for (int k = 0; k <= NUM_POINTS/2; k++) r_sz[k] <= '0;
      for (int k = 0; k < NUM_NTWRKS; k++) r_top[k] <= '0;
      r_next_id <= IDW'(1);
      r_rda <= '0;
      r_rdb <= '0;
      r_ida <= '0;
      r_idb <= '0;
      r_a <= '0;
      r_b <= '0;
      r_addr <= '0;
      r_conn_cnt <= '0;
      r_flush_pend <= 1'b0;
      r_out <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_addr <= PW'(1);
          if (w_acc) begin
            r_a <= pointa_in;
            r_b <= pointb_in;
            r_rda <= r_pt_id[pointa_in];
            r_rdb <= r_pt_id[pointb_in];
            r_conn_cnt <= r_conn_cnt + CW'(1);
            r_flush_pend <= flush;
          end
        end
        LOOKUP: begin
          r_ida <= r_rda;
          r_idb <= r_rdb;
        end
        DECIDE: begin
          r_addr <= w_merge ? '0 : PW'(1);
          if (w_alloc) begin
            r_pt_id[r_a] <= r_next_id;
            r_pt_id[r_b] <= r_next_id;
            r_sz[r_next_id] <= SW'(2);
            r_next_id <= r_next_id + IDW'(1);
          end
          if (w_join) begin
            r_pt_id[(r_ida == '0) ? r_a : r_b] <= w_jid;
            r_sz[w_jid] <= r_sz[w_jid] + SW'(1);
          end
        end
        MERGE: begin
          // network idb is folded into ida; idb is never reissued
          if (r_pt_id[r_addr] == r_idb) r_pt_id[r_addr] <= r_ida;
          r_addr <= w_last_m ? PW'(1) : r_addr + PW'(1);
          if (w_last_m) begin
            r_sz[r_ida] <= r_sz[r_ida] + r_sz[r_idb];
            r_sz[r_idb] <= '0;
          end
        end
        REPORT: begin
          r_addr <= r_addr + PW'(1);
          for (int k = 0; k < NUM_NTWRKS; k++) r_top[k] <= w_ins[k];
          if (w_last_r) for (int k = 0; k < NUM_NTWRKS; k++) r_out[k*SW +: SW] <= w_ins[k];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ntwrk_merge_ctrl.sv
// tb_ntwrk_merge_ctrl: vector table, hand sequences and random pair streams checked against a union-find model
module tb_ntwrk_merge_ctrl;
  localparam int NP = 8;
  localparam int NK = 3;
  localparam int SW = $clog2(NP+1);
  logic clk = 0;
  logic rst_n = 0;
  logic [2:0] pa = 0, pb = 0, qa = 0, qb = 0;
  logic vld = 0, fl = 0, qvld = 0, qfl = 0;
  logic rdy, busy, svld, qrdy, qbusy, qsvld;
  logic [NK*SW-1:0] sz, qsz;
  int n_chk = 0, n_pass = 0, acc = 0, q_acc = 0;
  int par [NP];
  bit inn [NP];
  int me [NK];
  typedef struct packed {
    logic [31:0] n;
    logic [31:0] pr;
    logic [3:0] e0, e1, e2;
  } vec_t;
  vec_t tv [6];
  always #5 clk = ~clk;
  ntwrk_merge_ctrl #(.NUM_POINTS(NP), .NUM_NTWRKS(NK), .NUM_CONN(16)) dut (
    .clk(clk), .rst_n(rst_n), .pointa_in(pa), .pointb_in(pb), .points_vld(vld), .points_rdy(rdy),
    .flush(fl), .busy(busy), .ntwrk_sz(sz), .ntwrk_sz_vld(svld));
  ntwrk_merge_ctrl #(.NUM_POINTS(NP), .NUM_NTWRKS(NK), .NUM_CONN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pointa_in(qa), .pointb_in(qb), .points_vld(qvld), .points_rdy(qrdy),
    .flush(qfl), .busy(qbusy), .ntwrk_sz(qsz), .ntwrk_sz_vld(qsvld));
  always @(posedge clk) begin
    if (vld && rdy) acc <= acc + 1;
    if (qvld && qrdy) q_acc <= q_acc + 1;
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  function automatic int root(input int x);
    int r = x;
    while (par[r] != r) r = par[r];
    return r;
  endfunction
  function automatic void m_reset();
    for (int i = 0; i < NP; i++) begin
      par[i] = i;
      inn[i] = 0;
    end
  endfunction
  function automatic int m_pair(input int a, input int b);
    int ra, rb, mg;
    if (a == b) return 0;
    ra = root(a);
    rb = root(b);
    mg = (inn[a] && inn[b] && ra != rb) ? 1 : 0;
    if (ra != rb) par[ra] = rb;
    inn[a] = 1;
    inn[b] = 1;
    return mg;
  endfunction
  function automatic void m_top();
    int cnt [NP];
    int bi;
    for (int i = 0; i < NP; i++) cnt[i] = 0;
    for (int p = 0; p < NP; p++) if (inn[p]) cnt[root(p)]++;
    for (int k = 0; k < NK; k++) begin
      bi = 0;
      for (int j = 1; j < NP; j++) if (cnt[j] > cnt[bi]) bi = j;
      me[k] = cnt[bi];
      cnt[bi] = 0;
    end
  endfunction
  task automatic do_reset();
    vld = 0;
    fl = 0;
    qvld = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("rst_rdy", int'(rdy), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vld", int'(svld), 0);
    chk("rst_sz", int'(sz), 0);
    rst_n = 1;
    m_reset();
    @(negedge clk);
  endtask
  task automatic send(input int a, input int b, input bit f, input bit meas);
    int t, lat, mg;
    pa = 3'(a);
    pb = 3'(b);
    vld = 1;
    fl = f;
    t = 0;
    while (!rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rdy_wait", int'(rdy), 1);
    @(negedge clk);
    vld = 0;
    fl = 0;
    mg = m_pair(a, b);
    if (meas) begin
      lat = 1;
      while (!rdy && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("pair_lat(%0d,%0d)", a, b), lat, mg ? 11 : 3);
    end
  endtask
  task automatic do_flush();
    fl = 1;
    @(negedge clk);
    fl = 0;
  endtask
  task automatic check_result(input string tg, input int e0, input int e1, input int e2);
    int t, a0;
    int e [NK];
    e = '{e0, e1, e2};
    t = 0;
    while (!svld && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk({tg, "_vld"}, int'(svld), 1);
    for (int k = 0; k < NK; k++) chk($sformatf("%s_sz%0d", tg, k), int'(sz[k*SW +: SW]), e[k]);
    chk({tg, "_busy"}, int'(busy), 0);
    chk({tg, "_rdy"}, int'(rdy), 0);
    a0 = acc;
    fl = 1;
    vld = 1;
    repeat (3) @(negedge clk);
    fl = 0;
    vld = 0;
    chk({tg, "_hold_sz0"}, int'(sz[SW-1:0]), e[0]);
    chk({tg, "_hold_acc"}, acc - a0, 0);
  endtask
  initial begin
    int p, t, lat, a0, n;
    bit same;
    tv[0] = '{32'd3, 32'h00122301, 4'd4, 4'd0, 4'd0};
    tv[1] = '{32'd3, 32'h00561201, 4'd3, 4'd2, 4'd0};
    tv[2] = '{32'd3, 32'h00331001, 4'd2, 4'd0, 4'd0};
    tv[3] = '{32'd4, 32'h67452301, 4'd2, 4'd2, 4'd2};
    tv[4] = '{32'd4, 32'h24340201, 4'd5, 4'd0, 4'd0};
    tv[5] = '{32'd4, 32'h00445676, 4'd3, 4'd0, 4'd0};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int k = 0; k < int'(tv[i].n); k++) begin
        p = int'(tv[i].pr >> (8*k));
        if (i % 2 == 1 && k == int'(tv[i].n) - 1) send((p >> 4) & 7, p & 7, 1, 0);
        else send((p >> 4) & 7, p & 7, 0, 1);
      end
      if (i % 2 == 0) do_flush();
      check_result($sformatf("vec%0d", i), int'(tv[i].e0), int'(tv[i].e1), int'(tv[i].e2));
    end
    do_reset();
    a0 = q_acc;
    qa = 3'd0;
    qb = 3'd1;
    qvld = 1;
    t = 0;
    while (!qrdy && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("q_rdy0", int'(qrdy), 1);
    @(negedge clk);
    qa = 3'd2;
    qb = 3'd3;
    t = 1;
    while (!qrdy && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("q_lat", t, 3);
    @(negedge clk);
    t = 0;
    while (!qsvld && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("q_vld", int'(qsvld), 1);
    chk("q_sz0", int'(qsz[SW-1:0]), 2);
    chk("q_sz1", int'(qsz[2*SW-1:SW]), 2);
    chk("q_sz2", int'(qsz[3*SW-1:2*SW]), 0);
    repeat (4) @(negedge clk);
    chk("q_rdy_done", int'(qrdy), 0);
    chk("q_acc", q_acc - a0, 2);
    qvld = 0;
    do_reset();
    a0 = acc;
    send(0, 1, 0, 1);
    send(2, 3, 0, 1);
    pa = 3'd1;
    pb = 3'd2;
    vld = 1;
    chk("m5_rdy", int'(rdy), 1);
    @(negedge clk);
    void'(m_pair(1, 2));
    pa = 3'd4;
    pb = 3'd5;
    lat = 1;
    while (!rdy && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("m5_lat", lat, 11);
    @(negedge clk);
    vld = 0;
    void'(m_pair(4, 5));
    lat = 1;
    while (!rdy && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("m5_lat2", lat, 3);
    chk("m5_acc", acc - a0, 4);
    do_flush();
    m_top();
    check_result("t5", me[0], me[1], me[2]);
    do_reset();
    send(0, 1, 0, 1);
    send(2, 3, 0, 1);
    send(1, 2, 0, 0);
    repeat (4) @(negedge clk);
    chk("t6_busy", int'(busy), 1);
    do_reset();
    send(0, 2, 0, 1);
    send(4, 5, 1, 0);
    m_top();
    check_result("t6", me[0], me[1], me[2]);
    for (int r = 0; r < 25; r++) begin
      do_reset();
      n = int'($urandom_range(1, 12));
      same = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (same && k == n - 1) send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1, 0);
        else send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0, 1);
      end
      if (!same) do_flush();
      m_top();
      check_result($sformatf("rnd%0d", r), me[0], me[1], me[2]);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
